mul_11_recon_64: RTL and testbench

//  - Inverse of the 64-bit divide-by-11 datapath: rebuilds X = 11*Q + R from a 61-bit quotient Q and a 4-bit remainder R.
//  - Digit-serial: DIGIT_W bits of Q per cycle, LSB first, with a small running carry instead of a 64-bit multiplier.
//  - Sits on the consumer side of the divider.
//  - Uses: round-trip checking of the divider, and regenerating operands from stored (Q,R) pairs.

---
 rtl/div_const_pkg.sv | 17 +
 rtl/mul_11_recon_64_if.sv | 36 +++
 rtl/mul11_digit.sv | 25 ++
 rtl/mul_11_recon_64.sv | 106 ++++++++++
 tb/tb_mul_11_recon_64.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/div_const_pkg.sv
// Constants and state encoding shared by the divide-by-11 datapath and its
// reconstruction (multiply-back) counterpart.
package div_const_pkg;

    localparam int DIVISOR = 11;
    localparam int X_W     = 64;
    localparam int Q_W     = 61;
    localparam int R_W     = 4;
    localparam int CARRY_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : div_const_pkg

// File: rtl/mul_11_recon_64_if.sv
// Handshake bundle for the (Q,R) -> X reconstruction block.
// Optional MUL11_RECON_RCHK_EN adds the r_err flag alongside X/ovf.
interface mul_11_recon_64_if;
    import div_const_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [Q_W-1:0]   Q;
    logic [R_W-1:0]   R;
    logic             out_valid;
    logic             out_ready;
    logic [X_W-1:0]   X;
    logic             ovf;
`ifdef MUL11_RECON_RCHK_EN
    logic             r_err;

    modport master (
        output in_valid, Q, R, out_ready,
        input  in_ready, out_valid, X, ovf, r_err
    );
    modport slave (
        input  in_valid, Q, R, out_ready,
        output in_ready, out_valid, X, ovf, r_err
    );
`else
    modport master (
        output in_valid, Q, R, out_ready,
        input  in_ready, out_valid, X, ovf
    );
    modport slave (
        input  in_valid, Q, R, out_ready,
        output in_ready, out_valid, X, ovf
    );
`endif

endinterface : mul_11_recon_64_if

// File: rtl/mul11_digit.sv
// One digit of the times-11 multiply: t = 8d + 2d + d + cin, split into a
// DIGIT_W-bit product digit and a 4-bit carry (always fits, see width rule).
module mul11_digit
    import div_const_pkg::*;
#(
    parameter int DIGIT_W = 8
) (
    input  logic [DIGIT_W-1:0] d,
    input  logic [CARRY_W-1:0] cin,
    output logic [DIGIT_W-1:0] p,
    output logic [CARRY_W-1:0] cout
);

    logic [DIGIT_W+CARRY_W-1:0] d_ext;
    logic [DIGIT_W+CARRY_W-1:0] cin_ext;
    logic [DIGIT_W+CARRY_W-1:0] t;

    assign d_ext   = {{CARRY_W{1'b0}}, d};
    assign cin_ext = {{DIGIT_W{1'b0}}, cin};
    assign t       = (d_ext << 3) + (d_ext << 1) + d_ext + cin_ext;

    assign p    = t[DIGIT_W-1:0];
    assign cout = t[DIGIT_W+CARRY_W-1:DIGIT_W];

endmodule : mul11_digit

// File: rtl/mul_11_recon_64.sv
// Digit-serial reconstruction X = 11*Q + R (mod 2^64) with overflow flag.
// Optional MUL11_RECON_RCHK_EN: flag R > 10 on r_err, captured at accept.
module mul_11_recon_64
    import div_const_pkg::*;
#(
    parameter int DIGIT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mul_11_recon_64_if.slave     bus
);

    localparam int NDIG  = X_W / DIGIT_W;
    localparam int CNT_W = $clog2(NDIG + 1);

    state_t               state_reg;
    state_t               state_next;
    logic [X_W-1:0]       q_sr_reg;
    logic [X_W-1:0]       x_reg;
    logic [CARRY_W-1:0]   carry_reg;
    logic [CNT_W-1:0]     count_reg;
    logic                 ovf_reg;
    logic [DIGIT_W-1:0]   digit_p;
    logic [CARRY_W-1:0]   digit_cout;
    logic                 last_digit;
`ifdef MUL11_RECON_RCHK_EN
    logic                 r_err_reg;
`endif

    mul11_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .d    (q_sr_reg[DIGIT_W-1:0]),
        .cin  (carry_reg),
        .p    (digit_p),
        .cout (digit_cout)
    );

    assign last_digit = (count_reg == CNT_W'(NDIG - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid)  state_next = RUN;
            RUN:     if (last_digit)    state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Product digits enter at the MSB end so after NDIG shifts the first
    // (least significant) digit has walked down to bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sr_reg  <= '0;
            x_reg     <= '0;
            carry_reg <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
`ifdef MUL11_RECON_RCHK_EN
            r_err_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        q_sr_reg  <= {{(X_W-Q_W){1'b0}}, bus.Q};
                        carry_reg <= bus.R;
                        count_reg <= '0;
`ifdef MUL11_RECON_RCHK_EN
                        r_err_reg <= (bus.R > R_W'(DIVISOR - 1));
`endif
                    end
                end
                RUN: begin
                    x_reg     <= {digit_p, x_reg[X_W-1:DIGIT_W]};
                    q_sr_reg  <= {{DIGIT_W{1'b0}}, q_sr_reg[X_W-1:DIGIT_W]};
                    carry_reg <= digit_cout;
                    count_reg <= count_reg + CNT_W'(1);
                    if (last_digit) begin
                        ovf_reg <= (digit_cout != '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.X         = x_reg;
    assign bus.ovf       = ovf_reg;
`ifdef MUL11_RECON_RCHK_EN
    assign bus.r_err     = r_err_reg;
`endif

endmodule : mul_11_recon_64

// File: tb/tb_mul_11_recon_64.sv
// Self-checking bench for mul_11_recon_64: fixed vector table, handshake and
// reset sequences, then random operands against an 11*Q+R arithmetic model.
module tb_mul_11_recon_64;
    import div_const_pkg::*;

    localparam int DIGIT_W = 8;
    localparam int NDIG    = X_W / DIGIT_W;
    localparam int N_RAND  = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mul_11_recon_64_if bus ();

    mul_11_recon_64 #(
        .DIGIT_W (DIGIT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [60:0] q;
        logic [3:0]  r;
        logic [63:0] x;
        logic        ovf;
        logic        r_err;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [67:0] model(input logic [60:0] q, input logic [3:0] r);
        return 68'(q) * 68'(DIVISOR) + 68'(r);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    task automatic get_rerr(output logic e);
`ifdef MUL11_RECON_RCHK_EN
        e = bus.r_err;
`else
        e = 1'b0;
`endif
    endtask

    // Accepts one operand, waits for the result, holds out_ready low for
    // `hold` cycles (checking stability), then completes the handshake.
    task automatic run_op(input logic [60:0] q, input logic [3:0] r, input int hold,
                          output logic [63:0] x, output logic o, output logic e,
                          output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 1000) begin
            @(posedge clk); #1; guard++;
        end
        check("in_ready_before_accept", 64'(bus.in_ready), 64'(1));
        bus.Q = q;
        bus.R = r;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.Q = '0;
        bus.R = '0;
        lat = 0;
        while (!bus.out_valid && lat < 1000) begin
            @(posedge clk); #1; lat++;
        end
        x = bus.X;
        o = bus.ovf;
        get_rerr(e);
        for (int i = 0; i < hold; i++) begin
            logic e_now;
            @(posedge clk); #1;
            get_rerr(e_now);
            check("hold_X", bus.X, x);
            check("hold_ovf", 64'(bus.ovf), 64'(o));
            check("hold_out_valid", 64'(bus.out_valid), 64'(1));
            check("hold_in_ready", 64'(bus.in_ready), 64'(0));
            check("hold_r_err", 64'(e_now), 64'(e));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("out_valid_drop", 64'(bus.out_valid), 64'(0));
        check("in_ready_after_done", 64'(bus.in_ready), 64'(1));
    endtask

    initial begin
        logic [63:0] x, x2;
        logic        o, o2, e;
        int          lat;
        logic [67:0] full;
        logic [60:0] q;
        logic [3:0]  r;
        logic [63:0] qmax;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.Q         = '0;
        bus.R         = '0;

        tbl[0] = '{61'h0,                 4'd0,  64'h0,                  1'b0, 1'b0};
        tbl[1] = '{61'h1,                 4'd10, 64'd21,                 1'b0, 1'b0};
        tbl[2] = '{61'h0123456789ABCDE,   4'd7,  64'h00C83FB72EA61D91,   1'b0, 1'b0};
        tbl[3] = '{61'h1745D1745D1745D1,  4'd4,  64'hFFFFFFFFFFFFFFFF,   1'b0, 1'b0};
        tbl[4] = '{61'h1745D1745D1745D2,  4'd0,  64'h0000000000000006,   1'b1, 1'b0};
        tbl[5] = '{61'h1FFFFFFFFFFFFFFF,  4'd15, 64'h6000000000000004,   1'b1, 1'b1};
        tbl[6] = '{61'h2,                 4'd11, 64'd33,                 1'b0, 1'b1};
        tbl[7] = '{61'h5,                 4'd15, 64'h46,                 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'(0));
        check("reset_in_ready", 64'(bus.in_ready), 64'(1));
        check("reset_X", bus.X, 64'h0);
        check("reset_ovf", 64'(bus.ovf), 64'(0));
        get_rerr(e);
        check("reset_r_err", 64'(e), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            run_op(tbl[i].q, tbl[i].r, 0, x, o, e, lat);
            $display("vec %0d: Q=0x%h R=%0d -> X=0x%h ovf=%0d lat=%0d", i, tbl[i].q, tbl[i].r, x, o, lat);
            check("tbl_X", x, tbl[i].x);
            check("tbl_ovf", 64'(o), 64'(tbl[i].ovf));
            check("tbl_latency", 64'(lat), 64'(NDIG));
`ifdef MUL11_RECON_RCHK_EN
            check("tbl_r_err", 64'(e), 64'(tbl[i].r_err));
`endif
        end

        // Backpressure for 5 cycles, then the same op again back-to-back.
        run_op(61'h0123456789ABCDE, 4'd7, 5, x, o, e, lat);
        $display("backpressure: X=0x%h ovf=%0d", x, o);
        check("bp_X", x, 64'h00C83FB72EA61D91);
        run_op(61'h0123456789ABCDE, 4'd7, 0, x2, o2, e, lat);
        $display("back-to-back: X=0x%h ovf=%0d", x2, o2);
        check("b2b_X", x2, x);
        check("b2b_ovf", 64'(o2), 64'(o));

        // Reset during the third RUN cycle.
        bus.Q = 61'h1745D1745D1745D2;
        bus.R = 4'd3;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("mid-run reset: out_valid=%0d in_ready=%0d X=0x%h", bus.out_valid, bus.in_ready, bus.X);
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_mid_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_mid_X", bus.X, 64'h0);
        check("rst_mid_ovf", 64'(bus.ovf), 64'(0));
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(61'h0123456789ABCDE, 4'd7, 0, x, o, e, lat);
        $display("after reset: X=0x%h ovf=%0d", x, o);
        check("post_rst_X", x, 64'h00C83FB72EA61D91);
        check("post_rst_ovf", 64'(o), 64'(0));

        // Random operands: mostly within the legal range, some beyond it.
        qmax = 64'h1745D1745D1745D1;
        for (int n = 0; n < N_RAND; n++) begin
            logic [63:0] rq;
            rq = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) begin
                rq = rq % (qmax + 64'd1);
                r  = 4'($urandom_range(0, 10));
            end else begin
                r  = 4'($urandom_range(0, 15));
            end
            q = rq[60:0];
            full = model(q, r);
            run_op(q, r, $urandom_range(0, 1), x, o, e, lat);
            $display("rand %0d: Q=0x%h R=%0d -> X=0x%h ovf=%0d", n, q, r, x, o);
            check("rand_X", x, full[63:0]);
            check("rand_ovf", 64'(o), 64'(full[67:64] != 4'd0));
            check("rand_latency", 64'(lat), 64'(NDIG));
`ifdef MUL11_RECON_RCHK_EN
            check("rand_r_err", 64'(e), 64'(r > 4'd10));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mul_11_recon_64
